// File: rtl/hd_balance_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : hd_balance_sequencer_if
// Description : Bundle of the hd_balance_sequencer input handshake, scheduling
//               enable and rail/status outputs.
//               master : producer/observer side (drives enable, in_valid,
//                        in_data; receives in_ready and all rail/status outputs)
//               slave  : the sequencer itself
// Parameters  : CNT_W - width of the emitted-byte counter
// Revision    : 1.0 - initial release
// ============================================================================
interface hd_balance_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             enable;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic [7:0]       rail_a;
    logic [7:0]       rail_b;
    logic             rail_valid;
    logic             dummy;
    logic [3:0]       hd_sum;
    logic             balance_err;
    logic [CNT_W-1:0] byte_cnt;

    modport master (
        output enable,
        output in_valid,
        output in_data,
        input  in_ready,
        input  rail_a,
        input  rail_b,
        input  rail_valid,
        input  dummy,
        input  hd_sum,
        input  balance_err,
        input  byte_cnt
    );

    modport slave (
        input  enable,
        input  in_valid,
        input  in_data,
        output in_ready,
        output rail_a,
        output rail_b,
        output rail_valid,
        output dummy,
        output hd_sum,
        output balance_err,
        output byte_cnt
    );
endinterface
`default_nettype wire

// File: rtl/hd_balance_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hd_balance_sequencer
// Description : Front-end sequencer for the Hamming-distance balancing
//               datapath. Buffers plaintext bytes in a DEPTH-entry FIFO,
//               emits one byte per cycle on rail_a and toggles rail_b so that
//               the combined toggle count of both rails is 8 per update.
//               Optional LFSR dummy traffic (macro HD_BALANCE_DUMMY_EN) keeps
//               the rails moving while the FIFO is empty.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               bus (slave modport) - enable, in_valid/in_data/in_ready,
//                                     rail_a, rail_b, rail_valid, dummy,
//                                     hd_sum, balance_err, byte_cnt
// Parameters  : DEPTH - FIFO entries (power of 2, >= 2)
//               CNT_W - width of the emitted-byte counter
// Macro       : HD_BALANCE_DUMMY_EN - enables DUMMY state and the LFSR
// Revision    : 1.0 - initial release
// ============================================================================
module hd_balance_sequencer #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    hd_balance_sequencer_if.slave bus
);

    localparam int              c_aw    = $clog2(DEPTH);
    localparam logic [c_aw:0]   c_depth = (c_aw + 1)'(DEPTH);

    // State encoding; the state register records which kind of edge
    // happened last and directly decodes the rail_valid/dummy flags.
    localparam logic [1:0] c_st_off    = 2'd0;
    localparam logic [1:0] c_st_stream = 2'd2;
`ifdef HD_BALANCE_DUMMY_EN
    localparam logic [1:0] c_st_dummy  = 2'd3;
`else
    localparam logic [1:0] c_st_idle   = 2'd1;
`endif

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]       r_state;
    logic [7:0]       r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_aw:0]    r_count;
    logic [7:0]       r_rail_a;
    logic [7:0]       r_rail_b;
    logic [3:0]       r_hd_sum;
    logic             r_balance_err;
    logic [CNT_W-1:0] r_byte_cnt;
`ifdef HD_BALANCE_DUMMY_EN
    logic [7:0]       r_lfsr;
    logic [7:0]       w_lfsr_nxt;
`endif

    // ------------------------------------------------------------------
    // Combinational next-state / datapath
    // ------------------------------------------------------------------
    logic [1:0]       w_state_nxt;
    logic             w_in_ready;
    logic             w_push;
    logic             w_pop;
    logic             w_update;
    logic [7:0]       w_new_a;
    logic [3:0]       w_hd_a;
    logic [7:0]       w_mask;
    logic [4:0]       w_sum;

    function automatic logic [3:0] f_popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

`ifdef HD_BALANCE_DUMMY_EN
    // Fibonacci LFSR x^8+x^6+x^5+x^4+1, shifting left, feedback into bit 0.
    assign w_lfsr_nxt = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
`endif

    always_comb begin
        w_state_nxt = c_st_off;
        w_in_ready  = (r_count < c_depth);
        w_push      = bus.in_valid & w_in_ready;

        // The decision for this edge uses the pre-edge count and enable,
        // so a byte sitting in the FIFO is popped at the very next edge.
        if (bus.enable) begin
            if (r_count != '0) begin
                w_state_nxt = c_st_stream;
            end else begin
`ifdef HD_BALANCE_DUMMY_EN
                w_state_nxt = c_st_dummy;
`else
                w_state_nxt = c_st_idle;
`endif
            end
        end

        w_pop    = (w_state_nxt == c_st_stream);
        w_update = w_pop;
        w_new_a  = r_mem[r_rd_ptr];
`ifdef HD_BALANCE_DUMMY_EN
        if (w_state_nxt == c_st_dummy) begin
            w_update = 1'b1;
            w_new_a  = w_lfsr_nxt;
        end
`endif

        // Balancing path: rail_b toggles exactly (8 - hd_a) low-order bits.
        // 0xFF >> hd_a equals ((1 << (8 - hd_a)) - 1) truncated to 8 bits
        // for every hd_a in 0..8.
        w_hd_a = f_popcount8(r_rail_a ^ w_new_a);
        w_mask = 8'hFF >> w_hd_a;
        w_sum  = {1'b0, w_hd_a} + {1'b0, f_popcount8(w_mask)};
    end

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_st_off;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_rail_a      <= 8'h00;
            r_rail_b      <= 8'h00;
            r_hd_sum      <= 4'd0;
            r_balance_err <= 1'b0;
            r_byte_cnt    <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            if (w_pop) begin
                r_rd_ptr   <= r_rd_ptr + c_aw'(1);
                r_byte_cnt <= r_byte_cnt + CNT_W'(1);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_aw + 1)'(1);
                2'b01:   r_count <= r_count - (c_aw + 1)'(1);
                default: r_count <= r_count;
            endcase

            if (w_update) begin
                r_rail_a <= w_new_a;
                r_rail_b <= r_rail_b ^ w_mask;
                r_hd_sum <= w_sum[3:0];
                if (w_sum != 5'd8) begin
                    r_balance_err <= 1'b1;
                end
            end else begin
                r_hd_sum <= 4'd0;
            end
        end
    end

`ifdef HD_BALANCE_DUMMY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_lfsr <= 8'hA5;
        end else if (w_state_nxt == c_st_dummy) begin
            r_lfsr <= w_lfsr_nxt;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.in_ready    = w_in_ready;
    assign bus.rail_a      = r_rail_a;
    assign bus.rail_b      = r_rail_b;
    assign bus.rail_valid  = (r_state == c_st_stream);
`ifdef HD_BALANCE_DUMMY_EN
    assign bus.dummy       = (r_state == c_st_dummy);
`else
    assign bus.dummy       = 1'b0;
`endif
    assign bus.hd_sum      = r_hd_sum;
    assign bus.balance_err = r_balance_err;
    assign bus.byte_cnt    = r_byte_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hd_balance_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hd_balance_sequencer
// Description : Self-checking bench for hd_balance_sequencer. A queue-based
//               reference model predicts every output after each clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hd_balance_sequencer;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;
`ifdef HD_BALANCE_DUMMY_EN
    localparam bit c_dummy_on = 1'b1;
`else
    localparam bit c_dummy_on = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    hd_balance_sequencer_if #(.CNT_W(CNT_W)) bus ();

    hd_balance_sequencer #(
        .DEPTH (DEPTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0]       q[$];
    logic [7:0]       m_a, m_b, m_lfsr;
    logic             m_valid, m_dummy, m_err;
    logic [3:0]       m_hd;
    logic [CNT_W-1:0] m_cnt;

    task automatic model_reset();
        q.delete();
        m_a = 8'h00; m_b = 8'h00; m_lfsr = 8'hA5;
        m_valid = 1'b0; m_dummy = 1'b0; m_err = 1'b0;
        m_hd = 4'd0; m_cnt = '0;
    endtask

    // New byte onto rail_a; rail_b toggles just enough bits to reach 8.
    task automatic model_apply(input logic [7:0] nb);
        int         d;
        int         total;
        logic [7:0] mask;
        d    = $countones(m_a ^ nb);
        mask = 8'h00;
        for (int i = 0; i < 8 - d; i++) mask[i] = 1'b1;
        m_b   = m_b ^ mask;
        m_a   = nb;
        total = d + $countones(mask);
        m_hd  = total[3:0];
        if (total != 8) m_err = 1'b1;
    endtask

    task automatic tick(input bit r, input bit en, input bit v, input logic [7:0] d);
        bit push;
        rst = r; bus.enable = en; bus.in_valid = v; bus.in_data = d;
        if (r) begin
            model_reset();
        end else begin
            push    = v && (q.size() < DEPTH);
            m_valid = 1'b0; m_dummy = 1'b0; m_hd = 4'd0;
            if (en && q.size() > 0) begin
                model_apply(q.pop_front());
                m_valid = 1'b1;
                m_cnt   = m_cnt + 1'b1;
            end else if (en && c_dummy_on) begin
                m_lfsr = {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
                model_apply(m_lfsr);
                m_dummy = 1'b1;
            end
            if (push) q.push_back(d);
        end
        @(posedge clk);
        #1;
        check("rail_a",      bus.rail_a,      m_a);
        check("rail_b",      bus.rail_b,      m_b);
        check("rail_valid",  bus.rail_valid,  m_valid);
        check("dummy",       bus.dummy,       m_dummy);
        check("hd_sum",      bus.hd_sum,      m_hd);
        check("balance_err", bus.balance_err, m_err);
        check("byte_cnt",    bus.byte_cnt,    m_cnt);
        check("in_ready",    bus.in_ready,    (q.size() < DEPTH));
    endtask

    logic [7:0] b_prev, b_inv;

    initial begin
        rst = 1'b1; bus.enable = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
        model_reset();

        // Reset state
        tick(1, 0, 0, 8'h00);
        tick(1, 0, 0, 8'h00);

        // Back-to-back 0x00, 0xFF, 0x0F
        tick(0, 1, 1, 8'h00);
        tick(0, 1, 1, 8'hFF);
        tick(0, 1, 1, 8'h0F);
        tick(0, 1, 0, 8'h00);
        check("plan1_rail_b", bus.rail_b, 8'hF0);
        check("plan1_cnt", bus.byte_cnt, 3);
        tick(0, 0, 0, 8'h00);

        // Fill while disabled, fifth push refused, then drain
        for (int i = 1; i <= 5; i++) begin
            tick(0, 0, 1, 8'(i * 8'h11));
            if (i == 4) check("full_ready", bus.in_ready, 0);
        end
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 8'h00);

        // Repeated byte: hd_a = 0 flips every rail_b bit
        tick(0, 1, 1, 8'h3C);
        tick(0, 1, 1, 8'h3C);
        b_prev = bus.rail_b;
        tick(0, 1, 0, 8'h00);
        b_inv = ~b_prev;
        check("repeat_rail_b", bus.rail_b, b_inv);
        tick(0, 0, 0, 8'h00);

        // Reset with bytes queued
        tick(0, 0, 1, 8'hA1);
        tick(0, 0, 1, 8'hA2);
        tick(0, 0, 1, 8'hA3);
        tick(1, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) tick(0, 1, 0, 8'h00);

        // Empty FIFO, enable high: dummy traffic or hold, then preemption
        tick(1, 0, 0, 8'h00);
        for (int i = 0; i < 20; i++) tick(0, 1, 0, 8'h00);
        tick(0, 1, 1, 8'h5A);
        tick(0, 1, 0, 8'h00);
        tick(0, 1, 0, 8'h00);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 1) == 1), 8'($urandom));
        end

        // Stream 65536 bytes so byte_cnt wraps
        tick(1, 0, 0, 8'h00);
        for (int i = 0; i < 65536; i++) tick(0, 1, 1, 8'($urandom));
        for (int i = 0; i < 3; i++) tick(0, 1, 0, 8'h00);
        check("wrap_cnt", bus.byte_cnt, 0);
        check("wrap_err", bus.balance_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/hd_balance_sequencer.md
# hd_balance_sequencer

Front-end sequencer for the Hamming-distance balancing datapath. It buffers incoming plaintext bytes in a small FIFO and schedules one byte per cycle onto a primary rail. It drives a complementary balancing rail so that the summed toggle count of both rails is exactly 8 on every update cycle. Optionally it fills idle cycles with LFSR dummy traffic so that power activity never stops.

## Interface
- DEPTH, 4, FIFO entries; power of 2, ≥2
- CNT_W, 16, width of emitted-byte counter
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  scheduling enable; 0 freezes rails, FIFO still accepts
- in_valid  in  1  input byte present
- in_data  in  8  input byte
- in_ready  out  1  FIFO can accept; (count < DEPTH), registered-state only, no combinational path from in_valid
- rail_a  out  8  primary rail (real or dummy byte)
- rail_b  out  8  balancing rail
- rail_valid  out  1  rail_a carries a real byte this cycle
- dummy  out  1  rail_a carries a dummy byte this cycle
- hd_sum  out  4  HD(rail_a) + HD(rail_b) of last update; 0 on hold cycles
- balance_err  out  1  sticky self-check flag
- byte_cnt  out  CNT_W  real bytes emitted, wraps

## Operation
- Reset values: rail_a=0x00, rail_b=0x00, rail_valid=0, dummy=0, hd_sum=0, balance_err=0, byte_cnt=0, FIFO empty, in_ready=1, LFSR=0xA5, state OFF.
- Push: in_valid & in_ready at an edge writes in_data to the FIFO tail.
- States:
  - OFF: enable=0; rails hold.
  - IDLE: enable=1, FIFO empty, dummy traffic disabled.
  - STREAM: enable=1, FIFO non-empty.
  - DUMMY: enable=1, FIFO empty, dummy traffic enabled.
- Transitions are evaluated every edge from enable and the pre-edge FIFO count. Any state can go to any other state in one cycle.
- STREAM update at an edge:
  - Pop the head into new rail_a.
  - hd_a = popcount(old rail_a ^ new rail_a), range 0..8.
  - mask = (1 << (8 − hd_a)) − 1, computed 9-bit and truncated to 8 bits. hd_a=0 gives 0xFF; hd_a=8 gives 0x00.
  - new rail_b = old rail_b ^ mask.
  - hd_sum = hd_a + popcount(mask).
  - rail_valid=1; byte_cnt += 1, modulo 2^CNT_W.
- Hold cycles (OFF or IDLE): rails unchanged; rail_valid=0, dummy=0, hd_sum=0.
- balance_err is set on any update cycle where the computed hd_sum ≠ 8. It clears only on rst.
- Simultaneous push and pop: both happen, count is unchanged. Push into a full FIFO is impossible because in_ready=0; a pop in the same cycle does not raise in_ready early.
- Reset mid-operation: FIFO content discarded and all outputs return to their reset values at that edge.

## Timing
- All outputs are registered.
- A byte accepted at edge N with an empty FIFO and enable=1 appears on rail_a after edge N+1, with rail_valid=1. Latency is 1 cycle.
- Throughput is 1 byte/cycle sustained; FIFO order is preserved.
- in_ready falls the cycle after the DEPTH-th entry is written. It rises the cycle after the first pop from full.
- enable deasserted at edge N: the update at edge N is suppressed.

## Configuration
- HD_BALANCE_DUMMY_EN defined:
  - DUMMY state exists.
  - Each DUMMY cycle advances the 8-bit Fibonacci LFSR: polynomial x^8+x^6+x^5+x^4+1, shift left, feedback into bit 0.
  - The new LFSR value is used as new rail_a through the same balancing path.
  - dummy=1, rail_valid=0, hd_sum=8; byte_cnt unchanged.
  - The LFSR advances only in DUMMY cycles.
- Undefined: empty FIFO with enable=1 means IDLE (hold). The LFSR is not instantiated and dummy is tied 0.

## Test plan
- Reset, enable=1, push 0x00, 0xFF, 0x0F back-to-back -> rail_a sequence 0x00/0xFF/0x0F; rail_b 0xFF/0xFF/0xF0; hd_sum 8 each; byte_cnt=3; balance_err=0.
- enable=0, push 5 bytes 0x11..0x55 -> in_ready low after 4th; 0x55 not accepted. Then enable=1 -> 0x11..0x44 on four consecutive cycles; in_ready=1 the cycle after the first pop.
- Push 0x3C at edge N, then 0x3C again -> rail_valid at N+1. Second update: hd_a=0, rail_b toggles all bits, hd_sum=8.
- Mid-stream rst with 3 bytes queued -> next cycle: all outputs at reset values, FIFO empty, no stale byte emitted after release.
- With HD_BALANCE_DUMMY_EN, empty FIFO, enable=1 for 20 cycles -> dummy=1 and hd_sum=8 every cycle; rail_a matches the LFSR model seeded 0xA5; a pushed byte preempts DUMMY with 1-cycle latency. Without the macro: rails hold and hd_sum=0.
- Stream 65536 bytes -> byte_cnt wraps to 0; balance_err stays 0 throughout.
